// File: rtl/pipelined_adder_pkg.sv
// rtl/pipelined_adder_pkg.sv - shared constants and stage payload type for pipelined_adder
package pipelined_adder_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CHUNK = 8;
  // Payload fields are sized for the widest supported adder; bits above WIDTH stay zero.
  localparam int MAX_WIDTH = 128;

  typedef struct packed {
    logic [MAX_WIDTH-1:0] a;    // unconsumed operand slices, next slice at bit 0
    logic [MAX_WIDTH-1:0] b;
    logic [MAX_WIDTH-1:0] sum;  // completed sum slices at their final bit position
    logic                 carry;
    logic                 c_msb;
    logic                 sub;
  } stage_payload_t;

endpackage

// File: rtl/pipelined_adder_chunk.sv
// rtl/pipelined_adder_chunk.sv - combinational CHUNK-bit ripple adder slice
module adder_chunk
  import pipelined_adder_pkg::*;
#(
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - pipelined WIDTH-bit adder/subtractor, one CHUNK-bit slice per stage
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int CHUNK_SAFE = (CHUNK >= 1) ? CHUNK : 1;
  localparam int NSTAGE     = WIDTH / CHUNK_SAFE;

  if (CHUNK < 1 || (WIDTH % CHUNK_SAFE) != 0 || WIDTH > MAX_WIDTH) begin : g_param_check
    $error("pipelined_adder: WIDTH must be a nonzero multiple of CHUNK and at most %0d", MAX_WIDTH);
  end

  logic [NSTAGE:0]      ready;
  logic [NSTAGE-1:0]    v_q, v_d;
  stage_payload_t       pipe_q [NSTAGE];
  stage_payload_t       pipe_d [NSTAGE];

  logic [NSTAGE-1:0]    up_valid, up_carry, up_sub, ch_cout, ch_cmsb;
  logic [MAX_WIDTH-1:0] up_a   [NSTAGE];
  logic [MAX_WIDTH-1:0] up_b   [NSTAGE];
  logic [MAX_WIDTH-1:0] up_sum [NSTAGE];
  logic [CHUNK-1:0]     op_b   [NSTAGE];
  logic [CHUNK-1:0]     ch_sum [NSTAGE];

  // Stage 0 takes its operands straight from the input port; later stages from the previous register.
  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign up_valid[k] = in_valid;
      assign up_a[k]     = MAX_WIDTH'(in_a);
      assign up_b[k]     = MAX_WIDTH'(in_b);
      assign up_sum[k]   = '0;
      assign up_carry[k] = in_cin ^ in_sub;
      assign up_sub[k]   = in_sub;
    end else begin : g_body
      assign up_valid[k] = v_q[k-1];
      assign up_a[k]     = pipe_q[k-1].a;
      assign up_b[k]     = pipe_q[k-1].b;
      assign up_sum[k]   = pipe_q[k-1].sum;
      assign up_carry[k] = pipe_q[k-1].carry;
      assign up_sub[k]   = pipe_q[k-1].sub;
    end

    assign op_b[k] = up_b[k][CHUNK-1:0] ^ {CHUNK{up_sub[k]}};

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a     (up_a[k][CHUNK-1:0]),
      .b     (op_b[k]),
      .cin   (up_carry[k]),
      .sum   (ch_sum[k]),
      .cout  (ch_cout[k]),
      .c_msb (ch_cmsb[k])
    );
  end

  always_comb begin
    ready         = '0;
    ready[NSTAGE] = out_ready;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      ready[k] = ~v_q[k] | ready[k + 1];
    end
  end

  always_comb begin
    v_d    = v_q;
    pipe_d = pipe_q;
    for (int k = 0; k < NSTAGE; k++) begin
      if (ready[k]) begin
        v_d[k] = up_valid[k];
        if (up_valid[k]) begin
          pipe_d[k].a     = up_a[k] >> CHUNK;
          pipe_d[k].b     = up_b[k] >> CHUNK;
          pipe_d[k].sum   = up_sum[k] | (MAX_WIDTH'(ch_sum[k]) << (k * CHUNK));
          pipe_d[k].carry = ch_cout[k];
          pipe_d[k].c_msb = ch_cmsb[k];
          pipe_d[k].sub   = up_sub[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int k = 0; k < NSTAGE; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      v_q    <= v_d;
      pipe_q <= pipe_d;
    end
  end

  assign in_ready  = ready[0];
  assign out_valid = v_q[NSTAGE-1];
  assign out_sum   = pipe_q[NSTAGE-1].sum[WIDTH-1:0];
  assign out_cout  = pipe_q[NSTAGE-1].carry;
  assign out_ovf   = pipe_q[NSTAGE-1].c_msb ^ pipe_q[NSTAGE-1].carry;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - randomized self-checking bench for pipelined_adder
module tb_pipelined_adder;

  localparam int W  = 32;
  localparam int C  = 8;
  localparam int NS = W / C;
  localparam longint SMAX = 64'sh7FFF_FFFF;
  localparam longint SMIN = -64'sh8000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, in_cin, in_sub, out_valid, out_ready, out_cout, out_ovf;
  logic [W-1:0] in_a, in_b, out_sum;
  logic         in_valid_1, in_ready_1, in_cin_1, in_sub_1, out_valid_1, out_ready_1, out_cout_1, out_ovf_1;
  logic [W-1:0] in_a_1, in_b_1, out_sum_1;

  pipelined_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .in_sub(in_sub), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  pipelined_adder #(.WIDTH(W), .CHUNK(W)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_1), .in_ready(in_ready_1), .in_a(in_a_1), .in_b(in_b_1),
    .in_cin(in_cin_1), .in_sub(in_sub_1), .out_valid(out_valid_1), .out_ready(out_ready_1),
    .out_sum(out_sum_1), .out_cout(out_cout_1), .out_ovf(out_ovf_1)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Returns {cout, ovf, sum} from integer arithmetic on the operands.
  function automatic logic [33:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic cin, input logic sub);
    longint          sa, sb, s;
    longint unsigned ua, ub;
    logic            co, ov;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (sub) begin
      s  = sa - sb - longint'(cin);
      co = (ua >= ub + longint'(cin));
    end else begin
      s  = sa + sb + longint'(cin);
      co = ((ua + ub + longint'(cin)) > 64'hFFFF_FFFF);
    end
    ov = (s > SMAX) || (s < SMIN);
    return {co, ov, s[31:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [33:0] exp;
    int          acc;
  } exp_t;

  exp_t        sb_q[$];
  int          deliv[$];
  exp_t        e;
  logic        lat_chk = 1'b0;
  logic        stalled = 1'b0;
  logic [34:0] held;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) check_eq("stall_hold", {out_valid, out_cout, out_ovf, out_sum}, held);
      check_eq("in_ready", in_ready, (sb_q.size() < NS) || out_ready);
      check_eq("occupancy_le_nstage", sb_q.size() <= NS, 1'b1);
      if (sb_q.size() == 0) check_eq("spurious_out_valid", out_valid, 1'b0);
      if (out_valid && out_ready && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_eq("result", {out_cout, out_ovf, out_sum}, e.exp);
        if (lat_chk) check_eq("latency", 64'(cyc - e.acc), 64'(NS - 1));
        deliv.push_back(cyc);
      end
      stalled = out_valid && !out_ready;
      held    = {out_valid, out_cout, out_ovf, out_sum};
      if (in_valid && in_ready) sb_q.push_back('{ref_model(in_a, in_b, in_cin, in_sub), cyc + 1});
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
    logic done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
    for (int t = 0; t < 64 && !done; t++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check_eq("send_accepted", done, 1'b1);
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 200 && sb_q.size() != 0; t++) idle(1);
    check_eq("drain_empty", sb_q.size(), 0);
  endtask

  logic [31:0] dir_a   [7] = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h5, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF};
  logic [31:0] dir_b   [7] = '{32'h1, 32'h0, 32'h1, 32'h7, 32'h1, 32'h0, 32'hFFFF_FFFF};
  logic        dir_cin [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic        dir_sub [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  logic src_done;
  int   n0;
  logic [31:0] ra, rb;
  logic        rc, rs;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
    in_valid_1 = 1'b0; in_a_1 = '0; in_b_1 = '0; in_cin_1 = 1'b0; in_sub_1 = 1'b0; out_ready_1 = 1'b1;
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset_out_valid", out_valid, 1'b0);
    check_eq("reset_in_ready", in_ready, 1'b1);
    check_eq("reset_out_bits", {out_cout, out_ovf, out_sum}, 34'd0);
    check_eq("reset_out_valid_n1", out_valid_1, 1'b0);
    check_eq("reset_in_ready_n1", in_ready_1, 1'b1);
    check_eq("reset_out_sum_n1", out_sum_1, 32'd0);
    @(posedge clk); #1;

    // Directed corner vectors, back-to-back, with exact latency checked.
    lat_chk = 1'b1;
    for (int i = 0; i < 7; i++) send(dir_a[i], dir_b[i], dir_cin[i], dir_sub[i]);
    wait_drain();
    lat_chk = 1'b0;

    // Backpressure: out_ready low for cycles 3..8 of a 10-transaction stream.
    src_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) send($urandom, $urandom, 1'($urandom), 1'($urandom));
      end
      begin
        out_ready = 1'b1;
        idle(3);
        out_ready = 1'b0;
        idle(6);
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Bubble collapse with the output stalled.
    out_ready = 1'b0;
    send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    idle(2);
    send(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b1);
    idle(4);
    @(negedge clk);
    check_eq("bubble_out_valid", out_valid, 1'b1);
    check_eq("bubble_in_ready", in_ready, 1'b1);
    n0 = deliv.size();
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain();
    check_eq("bubble_count", deliv.size() - n0, 2);
    if (deliv.size() - n0 == 2) check_eq("bubble_consecutive", deliv[n0 + 1] - deliv[n0], 1);

    // Reset with three transactions in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_out_valid", out_valid, 1'b0);
    check_eq("midrst_in_ready", in_ready, 1'b1);
    check_eq("midrst_out_sum", out_sum, 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(8);

    // Long random stream with random backpressure and idle gaps.
    src_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          send(rand_op(), rand_op(), 1'($urandom), 1'($urandom));
          if ($urandom_range(3) == 0) idle($urandom_range(2));
        end
        src_done = 1'b1;
      end
      begin
        while (!src_done) begin
          out_ready = ($urandom_range(3) != 0);
          idle(1);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Single-stage configuration: result one edge after acceptance.
    for (int i = 0; i < 10; i++) begin
      if (i < 7) begin
        ra = dir_a[i]; rb = dir_b[i]; rc = dir_cin[i]; rs = dir_sub[i];
      end else begin
        ra = rand_op(); rb = rand_op(); rc = 1'($urandom); rs = 1'($urandom);
      end
      in_valid_1 = 1'b1; in_a_1 = ra; in_b_1 = rb; in_cin_1 = rc; in_sub_1 = rs;
      @(negedge clk);
      check_eq("n1_in_ready", in_ready_1, 1'b1);
      @(posedge clk); #1;
      in_valid_1 = 1'b0;
      @(negedge clk);
      check_eq("n1_out_valid", out_valid_1, 1'b1);
      check_eq("n1_result", {out_cout_1, out_ovf_1, out_sum_1}, ref_model(ra, rb, rc, rs));
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
